udp_rx_pkt_writer: RTL and testbench

- Upstream stage of the 2048x9 dual-port UDP packet buffer RAM. Drives its write port (port A).
- Accepts a byte stream with last/error flags and writes each byte into the RAM. Bit 8 of every written word is the end-of-frame marker.
- Publishes a committed write pointer only when a frame completes cleanly. Errored, oversized or overflowing frames are rolled back, so the downstream reader never sees partial frames.
- Single clock domain; the reader's pointer arrives already in this domain.

---
 rtl/udp_rx_pkt_writer_if.sv | 25 ++
 rtl/udp_rx_pkt_writer.sv | 133 +++++++++++++
 tb/tb_udp_rx_pkt_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/udp_rx_pkt_writer_if.sv
// Byte stream into the UDP RX packet writer: payload byte, valid/ready handshake,
// end-of-frame and frame-error flags.
interface udp_rx_pkt_writer_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_err;
  logic       s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    output s_err,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    input  s_err,
    output s_ready
  );
endinterface

// File: rtl/udp_rx_pkt_writer.sv
// Writes a byte stream into the UDP packet RAM and publishes wr_ptr only for clean frames.
// Optional macro UDP_RX_MIN_LEN_EN: clean frames shorter than MIN_LEN are dropped too.
module udp_rx_pkt_writer #(
  parameter int ADDR_W  = 11,
  parameter int MAX_LEN = 1500,
  parameter int MIN_LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  udp_rx_pkt_writer_if.slave  s,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [8:0]          ram_din,
  output logic                ram_we,
  output logic                ram_ce,
  input  logic [ADDR_W:0]     rd_ptr,
  output logic [ADDR_W:0]     wr_ptr,
  output logic                frm_done,
  output logic [ADDR_W-1:0]   frm_start,
  output logic [10:0]         frm_len,
  output logic [15:0]         drop_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, COMMIT, DROP} state_t;

  localparam logic [ADDR_W:0] FULL_USED = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [11:0]     MAX_LEN_W = 12'(MAX_LEN);
  localparam logic [11:0]     MIN_LEN_W = 12'(MIN_LEN);
`ifdef UDP_RX_MIN_LEN_EN
  localparam logic            MIN_LEN_EN = 1'b1;
`else
  localparam logic            MIN_LEN_EN = 1'b0;
`endif

  state_t              state, state_n;
  logic [ADDR_W:0]     wp_work, wp_work_n;
  logic [ADDR_W:0]     wr_ptr_n;
  logic [10:0]         len, len_n;
  logic [ADDR_W-1:0]   frm_start_r, frm_start_n;
  logic                we_n;
  logic                drop_inc;
  logic                xfer;
  logic [ADDR_W:0]     used;
  logic                full;
  logic [11:0]         len_next;
  logic                too_long;
  logic                short_frm;
  logic                rollback;

  assign s.s_ready = (state != COMMIT);
  assign xfer      = s.s_valid & s.s_ready;

  // Occupancy is measured against the speculative pointer, so bytes of the
  // frame in flight already count against the reader's free space.
  assign used      = wp_work - rd_ptr;
  assign full      = (used == FULL_USED);
  assign len_next  = (state == IDLE) ? 12'd1 : ({1'b0, len} + 12'd1);
  assign too_long  = (len_next > MAX_LEN_W);
  assign short_frm = MIN_LEN_EN & s.s_last & (len_next < MIN_LEN_W);
  assign rollback  = full | too_long | (s.s_last & s.s_err) | short_frm;

  assign ram_ce    = ram_we;
  assign frm_done  = (state == COMMIT);
  assign frm_len   = frm_done ? len : '0;
  assign frm_start = frm_done ? frm_start_r : '0;

  always_comb begin
    state_n     = state;
    wp_work_n   = wp_work;
    wr_ptr_n    = wr_ptr;
    len_n       = len;
    frm_start_n = frm_start_r;
    we_n        = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      IDLE, WRITE: begin
        if (xfer) begin
          if (rollback) begin
            // A rolled-back frame is counted here only if this byte ends it;
            // otherwise DROP counts it when the tail arrives.
            wp_work_n = wr_ptr;
            drop_inc  = s.s_last;
            state_n   = s.s_last ? IDLE : DROP;
          end else begin
            we_n      = 1'b1;
            wp_work_n = wp_work + PTR_ONE;
            len_n     = len_next[10:0];
            if (state == IDLE) frm_start_n = wp_work[ADDR_W-1:0];
            state_n   = s.s_last ? COMMIT : WRITE;
          end
        end
      end
      COMMIT: begin
        wr_ptr_n = wp_work;
        state_n  = IDLE;
      end
      DROP: begin
        if (xfer && s.s_last) begin
          drop_inc = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wp_work     <= '0;
      wr_ptr      <= '0;
      len         <= '0;
      frm_start_r <= '0;
      drop_cnt    <= '0;
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      state       <= state_n;
      wp_work     <= wp_work_n;
      wr_ptr      <= wr_ptr_n;
      len         <= len_n;
      frm_start_r <= frm_start_n;
      ram_we      <= we_n;
      if (we_n) begin
        ram_addr <= wp_work[ADDR_W-1:0];
        ram_din  <= {s.s_last, s.s_data};
      end
      if (drop_inc && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_rx_pkt_writer.sv
// Scoreboard bench for udp_rx_pkt_writer: a frame-level model predicts RAM writes,
// commits, wr_ptr and drop_cnt; a negedge monitor compares what the DUT presents.
module tb_udp_rx_pkt_writer;
  localparam int ADDR_W  = 11;
  localparam int MAX_LEN = 1500;
  localparam int MIN_LEN = 8;
  localparam int DEPTH   = 2048;
  localparam int PTR_MOD = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] ram_addr;
  logic [8:0]  ram_din;
  logic        ram_we;
  logic        ram_ce;
  logic [11:0] rd_ptr;
  logic [11:0] wr_ptr;
  logic        frm_done;
  logic [10:0] frm_start;
  logic [10:0] frm_len;
  logic [15:0] drop_cnt;

  udp_rx_pkt_writer_if sif ();

  udp_rx_pkt_writer #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sif),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_ce    (ram_ce),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr),
    .frm_done  (frm_done),
    .frm_start (frm_start),
    .frm_len   (frm_len),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int addr; int din;} wr_exp_t;
  typedef struct {int start; int len;} cm_exp_t;
  wr_exp_t wr_q[$];
  cm_exp_t cm_q[$];

  int checks = 0;
  int errors = 0;
  int m_wr = 0;
  int m_rd = 0;
  int m_drop = 0;
  int last_xfer_cyc = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int v);
    m_rd   = v % PTR_MOD;
    rd_ptr = 12'(m_rd);
  endtask

  // Drives one byte and returns once it has been accepted.
  task automatic send_byte(input logic [7:0] d, input bit last, input bit err);
    int t;
    sif.s_valid = 1'b1;
    sif.s_data  = d;
    sif.s_last  = last;
    sif.s_err   = err;
    t = 0;
    while (!sif.s_ready && t < 50) begin
      tick();
      t++;
    end
    if (!sif.s_ready) checkOutput("s_ready_timeout", int'(sif.s_ready), 1);
    tick();
    last_xfer_cyc = cyc;
  endtask

  task automatic idle_bus();
    sif.s_valid = 1'b0;
    sif.s_last  = 1'b0;
    sif.s_err   = 1'b0;
  endtask

  // Frame-level model: bytes are stored until the first rollback cause; the frame
  // commits only when every byte was stored.
  task automatic applyStimulus(input int n, input bit err, input int base,
                               input int gap_pct, input bit settle);
    int used, free0, k;
    bit short_frm;
    used  = (m_wr - m_rd + PTR_MOD) % PTR_MOD;
    free0 = DEPTH - used;
    short_frm = 1'b0;
`ifdef UDP_RX_MIN_LEN_EN
    short_frm = (n < MIN_LEN);
`endif
    k = n;
    if (err || short_frm) k = n - 1;
    if (free0 < k) k = free0;
    if (MAX_LEN < k) k = MAX_LEN;
    for (int i = 0; i < k; i++)
      wr_q.push_back('{(m_wr + i) % DEPTH, ((i == n - 1) ? 256 : 0) + ((base + i) % 256)});
    if (k == n) begin
      cm_q.push_back('{m_wr % DEPTH, n});
      m_wr = (m_wr + n) % PTR_MOD;
    end else if (m_drop < 65535) begin
      m_drop++;
    end
    for (int i = 0; i < n; i++) begin
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        idle_bus();
        repeat ($urandom_range(1, 3)) tick();
      end
      send_byte(8'((base + i) % 256), (i == n - 1),
                (i == n - 1) ? err : 1'($urandom_range(1)));
    end
    idle_bus();
    if (settle) begin
      tick();
      tick();
      checkOutput("wr_ptr", int'(wr_ptr), m_wr);
      checkOutput("drop_cnt", int'(drop_cnt), m_drop);
    end
  endtask

  // Monitor: every RAM write and every commit pulse must match the next expectation.
  always @(negedge clk) begin
    if (ram_we) begin
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: addr %0d din 0x%0h at cycle %0d", ram_addr, ram_din, cyc);
      end else begin
        wr_exp_t e;
        e = wr_q.pop_front();
        checkOutput("ram_addr", int'(ram_addr), e.addr);
        checkOutput("ram_din", int'(ram_din), e.din);
        checkOutput("ram_ce", int'(ram_ce), 1);
      end
    end else if (ram_ce) begin
      checkOutput("ram_ce_idle", int'(ram_ce), 0);
    end
    if (frm_done) begin
      if (cm_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_frm_done: start %0d len %0d at cycle %0d", frm_start, frm_len, cyc);
      end else begin
        cm_exp_t c;
        c = cm_q.pop_front();
        checkOutput("frm_start", int'(frm_start), c.start);
        checkOutput("frm_len", int'(frm_len), c.len);
        checkOutput("frm_done_cycle", cyc, last_xfer_cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idle_bus();
    sif.s_data = 8'h00;
    set_rd(0);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_s_ready", int'(sif.s_ready), 1);
    checkOutput("reset_wr_ptr", int'(wr_ptr), 0);
    checkOutput("reset_drop_cnt", int'(drop_cnt), 0);
    checkOutput("reset_frm_done", int'(frm_done), 0);
    checkOutput("reset_frm_len", int'(frm_len), 0);
    checkOutput("reset_ram_we", int'(ram_we), 0);

    $display("[TB] 64-byte clean frame");
    applyStimulus(64, 1'b0, 0, 0, 1'b1);

    $display("[TB] errored frame, then clean frame at the same address");
    applyStimulus(10, 1'b1, 100, 0, 1'b1);
    applyStimulus(12, 1'b0, 200, 0, 1'b1);

    $display("[TB] reset in the middle of a frame");
    for (int i = 0; i < 5; i++)
      wr_q.push_back('{(m_wr + i) % DEPTH, (50 + i) % 256});
    for (int i = 0; i < 5; i++) send_byte(8'(50 + i), 1'b0, 1'b0);
    idle_bus();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    m_wr = 0;
    m_drop = 0;
    set_rd(0);
    tick();
    checkOutput("midreset_wr_ptr", int'(wr_ptr), 0);
    checkOutput("midreset_drop_cnt", int'(drop_cnt), 0);
    checkOutput("midreset_s_ready", int'(sif.s_ready), 1);

    $display("[TB] fill to 2040, then overflowing frame");
    applyStimulus(1020, 1'b0, 1, 0, 1'b1);
    applyStimulus(1020, 1'b0, 7, 0, 1'b1);
    checkOutput("prefill_wr_ptr", int'(wr_ptr), 2040);
    applyStimulus(20, 1'b0, 33, 0, 1'b1);

    $display("[TB] wrap-around frame");
    set_rd(2000);
    applyStimulus(16, 1'b0, 90, 0, 1'b1);
    checkOutput("wrap_wr_ptr", int'(wr_ptr), 2056);

    $display("[TB] oversized frame");
    set_rd(2056);
    applyStimulus(MAX_LEN + 1, 1'b0, 3, 0, 1'b1);

    $display("[TB] 4-byte frame");
    applyStimulus(4, 1'b0, 240, 0, 1'b1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 40; f++) begin
      int used;
      used = ($urandom_range(3) == 0) ? $urandom_range(2030, 2048) : $urandom_range(0, 1000);
      set_rd(m_wr - used + PTR_MOD);
      applyStimulus($urandom_range(1, 48), ($urandom_range(5) == 0), $urandom_range(255),
                    20, 1'($urandom_range(1)));
    end

    repeat (5) tick();
    checkOutput("final_wr_ptr", int'(wr_ptr), m_wr);
    checkOutput("final_drop_cnt", int'(drop_cnt), m_drop);
    checkOutput("write_queue_drained", wr_q.size(), 0);
    checkOutput("commit_queue_drained", cm_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
